syzygy_dac_cfg_sequencer: RTL

Upstream command source for the SYZYGY DAC SPI shifter. It replays a fixed table of 16-bit DAC configuration words after reset or on request, then accepts single host-issued words. For each word it presents dac_spi_full and holds dac_spi_start until the shifter takes the word. It detects completion by watching the shifter's dac_cs_n, and reports busy, done and error status to the host endpoints.

---
 rtl/syzygy_dac_pkg.sv | 48 ++++
 rtl/syzygy_dac_cfg_sequencer_if.sv | 12 +
 rtl/syzygy_dac_timeout_cnt.sv | 27 ++
 rtl/syzygy_dac_cfg_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/syzygy_dac_pkg.sv
// Shared types and constants for the SYZYGY DAC configuration sequencer:
// init-table contents, FSM state encoding and command-word field positions.
package syzygy_dac_pkg;

    localparam int unsigned DAC_WORD_W      = 16;
    localparam int unsigned DAC_IDX_W       = 4;
    localparam int unsigned DAC_TABLE_DEPTH = 16;

    // Command word layout: R/W flag, 7-bit register address, 8-bit data
    localparam int unsigned DAC_RW_BIT   = 15;
    localparam int unsigned DAC_ADDR_MSB = 14;
    localparam int unsigned DAC_ADDR_LSB = 8;
    localparam int unsigned DAC_DATA_MSB = 7;
    localparam int unsigned DAC_DATA_LSB = 0;

    typedef logic [DAC_WORD_W-1:0] dac_word_t;

    // Power-up register writes, replayed in index order
    localparam dac_word_t DAC_INIT_TABLE [DAC_TABLE_DEPTH] = '{
        16'h0020, 16'h0100, 16'h021F, 16'h0300,
        16'h041F, 16'h0500, 16'h0634, 16'h0700,
        16'h0800, 16'h0900, 16'h0A00, 16'h0B00,
        16'h0C00, 16'h0D00, 16'h0E00, 16'h0F00
    };

    typedef enum logic [2:0] {
        ST_POR,
        ST_LOAD,
        ST_START,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_GAP,
        ST_IDLE,
        ST_ERROR
    } seq_state_t;

    // Counter width able to hold the largest terminal count
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/syzygy_dac_cfg_sequencer_if.sv
// Word/start handshake between the configuration sequencer and the DAC SPI shifter.
interface syzygy_dac_cfg_sequencer_if;
    import syzygy_dac_pkg::*;

    logic      dac_spi_start;
    dac_word_t dac_spi_full;
    logic      dac_cs_n;

    modport master (output dac_spi_start, output dac_spi_full, input dac_cs_n);
    modport slave  (input dac_spi_start, input dac_spi_full, output dac_cs_n);

endinterface

// File: rtl/syzygy_dac_timeout_cnt.sv
// Saturating up-counter with synchronous clear; term_c flags that count has reached last.
module syzygy_dac_timeout_cnt #(
    parameter int unsigned W = 14
) (
    input  logic         okClk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         term_c
);

    logic [W-1:0] count;

    always_ff @(posedge okClk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && !term_c) begin
            count <= count + W'(1);
        end
    end

    assign term_c = (count == last);

endmodule

// File: rtl/syzygy_dac_cfg_sequencer.sv
// Replays the DAC init table after reset or init_go, then forwards single host words
// to the SPI shifter, using the shifter's cs_n to detect completion and timeouts.
module syzygy_dac_cfg_sequencer
    import syzygy_dac_pkg::*;
#(
    parameter int unsigned NUM_WORDS     = 8,
    parameter int unsigned POR_WAIT      = 1024,
    parameter int unsigned GAP_CYCLES    = 256,
    parameter int unsigned START_TIMEOUT = 1024,
    parameter int unsigned XFER_TIMEOUT  = 8192
) (
    input  logic                         okClk,
    input  logic                         reset,
    input  logic                         init_go,
    input  logic                         host_wr_req,
    input  logic [DAC_WORD_W-1:0]        host_wr_data,
    output logic                         host_wr_ack,
    syzygy_dac_cfg_sequencer_if.master   spi,
    output logic                         init_busy,
    output logic                         init_done,
    output logic                         init_error,
    output logic [DAC_IDX_W-1:0]         word_index
);

    localparam int unsigned CNT_W = cnt_width(POR_WAIT, GAP_CYCLES, START_TIMEOUT, XFER_TIMEOUT);
    localparam logic [DAC_IDX_W-1:0] LAST_IDX = DAC_IDX_W'(NUM_WORDS - 1);

    seq_state_t           state_q, state_n;
    logic                 host_mode_q, host_mode_n;
    logic [DAC_IDX_W-1:0] idx_q, idx_n;
    dac_word_t            full_q, full_n;
    logic                 start_q;
    logic                 ack_n, done_n, error_n;

    logic                 cnt_load_c, cnt_en_c, cnt_term_c;
    logic [CNT_W-1:0]     cnt_last_c;

    syzygy_dac_timeout_cnt #(.W(CNT_W)) u_cnt (
        .okClk  (okClk),
        .reset  (reset),
        .load   (cnt_load_c),
        .en     (cnt_en_c),
        .last   (cnt_last_c),
        .term_c (cnt_term_c)
    );

    always_ff @(posedge okClk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_POR;
            host_mode_q <= 1'b0;
            idx_q       <= '0;
            full_q      <= '0;
            start_q     <= 1'b0;
            host_wr_ack <= 1'b0;
            init_busy   <= 1'b1;
            init_done   <= 1'b0;
            init_error  <= 1'b0;
        end else begin
            state_q     <= state_n;
            host_mode_q <= host_mode_n;
            idx_q       <= idx_n;
            full_q      <= full_n;
            start_q     <= (state_n == ST_START);
            host_wr_ack <= ack_n;
            init_busy   <= !((state_n == ST_IDLE) || (state_n == ST_ERROR));
            init_done   <= done_n;
            init_error  <= error_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        host_mode_n = host_mode_q;
        idx_n       = idx_q;
        full_n      = full_q;
        ack_n       = 1'b0;
        done_n      = init_done;
        error_n     = init_error;
        cnt_load_c  = 1'b0;
        cnt_en_c    = 1'b0;
        cnt_last_c  = '0;

        case (state_q)
            ST_POR: begin
                cnt_en_c   = 1'b1;
                cnt_last_c = CNT_W'(POR_WAIT - 1);
                if (cnt_term_c) begin
                    state_n     = ST_LOAD;
                    idx_n       = '0;
                    host_mode_n = 1'b0;
                end
            end
            // Host word is taken in the cycle host_wr_ack is high
            ST_LOAD: begin
                full_n     = host_mode_q ? host_wr_data : DAC_INIT_TABLE[idx_q];
                state_n    = ST_START;
                cnt_load_c = 1'b1;
            end
            ST_START: begin
                cnt_en_c   = 1'b1;
                cnt_last_c = CNT_W'(START_TIMEOUT - 1);
                if (!spi.dac_cs_n) begin
                    state_n    = ST_WAIT_LOW;
                    cnt_load_c = 1'b1;
                end else if (cnt_term_c) begin
                    state_n = ST_ERROR;
                    error_n = 1'b1;
                end
            end
            // Transfer timeout runs from the sampled cs_n fall through both wait states
            ST_WAIT_LOW, ST_WAIT_HIGH: begin
                cnt_en_c   = 1'b1;
                cnt_last_c = CNT_W'(XFER_TIMEOUT - 1);
                if ((state_q == ST_WAIT_HIGH) && spi.dac_cs_n) begin
                    state_n    = ST_GAP;
                    cnt_load_c = 1'b1;
                end else if (cnt_term_c) begin
                    state_n = ST_ERROR;
                    error_n = 1'b1;
                end else begin
                    state_n = ST_WAIT_HIGH;
                end
            end
            ST_GAP: begin
                cnt_en_c   = 1'b1;
                cnt_last_c = CNT_W'(GAP_CYCLES - 1);
                if (cnt_term_c) begin
                    if (host_mode_q) begin
                        state_n = ST_IDLE;
                    end else if (idx_q == LAST_IDX) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n   = idx_q + DAC_IDX_W'(1);
                        state_n = ST_LOAD;
                    end
                end
            end
            ST_IDLE, ST_ERROR: begin
                if (init_go) begin
                    done_n      = 1'b0;
                    error_n     = 1'b0;
                    idx_n       = '0;
                    host_mode_n = 1'b0;
                    state_n     = ST_LOAD;
                end else if ((state_q == ST_IDLE) && host_wr_req) begin
                    ack_n       = 1'b1;
                    host_mode_n = 1'b1;
                    state_n     = ST_LOAD;
                end
            end
            default: begin
                state_n = ST_POR;
            end
        endcase
    end

    assign spi.dac_spi_start = start_q;
    assign spi.dac_spi_full  = full_q;
    assign word_index        = idx_q;

endmodule
